// File: rtl/wb_regfile.sv
// Writeback stage: selects ALU or load data, commits it to a 32x32 register file,
// and serves two combinational read ports with same-cycle write-through bypass.
module wb_regfile #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREG  = 32,
   parameter int unsigned CNT_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     regWrite_fin,
   input  logic                     memtoReg_fin,
   input  logic [XLEN-1:0]          DM_read_data_out,
   input  logic [XLEN-1:0]          ALU_res_fin,
   input  logic [$clog2(NREG)-1:0]  rd_fin,
   input  logic [$clog2(NREG)-1:0]  rs1_addr,
   input  logic [$clog2(NREG)-1:0]  rs2_addr,
   output logic [XLEN-1:0]          rs1_data,
   output logic [XLEN-1:0]          rs2_data,
   output logic [XLEN-1:0]          wb_data,
   output logic                     wb_commit,
   output logic [CNT_W-1:0]         wb_count
);

   localparam int unsigned AW = $clog2(NREG);

   logic [XLEN-1:0]  r_regs [NREG];
   logic [CNT_W-1:0] r_count;
   logic [XLEN-1:0]  w_wb_data;
   logic             w_commit;
   logic [XLEN-1:0]  w_rs1_data;
   logic [XLEN-1:0]  w_rs2_data;

   // Writeback select and commit qualification; x0 writes and reset cycles never commit
   always_comb begin
      w_wb_data = memtoReg_fin ? DM_read_data_out : ALU_res_fin;
      w_commit  = regWrite_fin & (rd_fin != AW'(0)) & ~rst;
   end

   // Read ports: x0 reads zero, then bypass, then array
   always_comb begin
      w_rs1_data = r_regs[rs1_addr];
      w_rs2_data = r_regs[rs2_addr];
      if (rs1_addr == AW'(0))
         w_rs1_data = '0;
      else if (w_commit && (rd_fin == rs1_addr))
         w_rs1_data = w_wb_data;
      if (rs2_addr == AW'(0))
         w_rs2_data = '0;
      else if (w_commit && (rd_fin == rs2_addr))
         w_rs2_data = w_wb_data;
   end

   // Register array; entry 0 is cleared by reset and never written afterwards
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREG); i++)
            r_regs[i] <= '0;
      end else if (w_commit) begin
         r_regs[rd_fin] <= w_wb_data;
      end
   end

   // Committed-write counter, wraps naturally
   always_ff @(posedge clk) begin
      if (rst)
         r_count <= '0;
      else if (w_commit)
         r_count <= r_count + CNT_W'(1);
   end

   assign wb_data   = w_wb_data;
   assign wb_commit = w_commit;
   assign rs1_data  = w_rs1_data;
   assign rs2_data  = w_rs2_data;
   assign wb_count  = r_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; a second instance with a 4-bit
// counter shares the stimulus to exercise counter wrap.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        regWrite_fin;
   logic        memtoReg_fin;
   logic [31:0] DM_read_data_out;
   logic [31:0] ALU_res_fin;
   logic [4:0]  rd_fin;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data, rs2_data, wb_data;
   logic        wb_commit;
   logic [31:0] wb_count;
   logic [31:0] s_rs1_data, s_rs2_data, s_wb_data;
   logic        s_wb_commit;
   logic [3:0]  s_wb_count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_regfile u_dut (
      .clk(clk), .rst(rst), .regWrite_fin(regWrite_fin), .memtoReg_fin(memtoReg_fin),
      .DM_read_data_out(DM_read_data_out), .ALU_res_fin(ALU_res_fin), .rd_fin(rd_fin),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .wb_data(wb_data), .wb_commit(wb_commit), .wb_count(wb_count)
   );

   wb_regfile #(.CNT_W(4)) u_dut_c4 (
      .clk(clk), .rst(rst), .regWrite_fin(regWrite_fin), .memtoReg_fin(memtoReg_fin),
      .DM_read_data_out(DM_read_data_out), .ALU_res_fin(ALU_res_fin), .rd_fin(rd_fin),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(s_rs1_data), .rs2_data(s_rs2_data),
      .wb_data(s_wb_data), .wb_commit(s_wb_commit), .wb_count(s_wb_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      regWrite_fin = 1'b0; memtoReg_fin = 1'b0;
      DM_read_data_out = '0; ALU_res_fin = '0; rd_fin = '0;
   endtask

   task automatic write_alu(input logic [4:0] rd, input logic [31:0] val);
      regWrite_fin = 1'b1; memtoReg_fin = 1'b0; ALU_res_fin = val; rd_fin = rd;
      tick();
      idle();
   endtask

   initial begin
      rst = 1'b1; idle(); rs1_addr = '0; rs2_addr = '0;
      tick();
      // A write request during reset must not commit
      regWrite_fin = 1'b1; rd_fin = 5'd5; ALU_res_fin = 32'h1111_1111; rs1_addr = 5'd5;
      #1;
      check("commit_in_reset", {31'b0, wb_commit}, 32'h0);
      check("rs1_in_reset", rs1_data, 32'h0);
      tick();
      rst = 1'b0; idle();
      #1;
      check("count_after_reset", wb_count, 32'd0);
      check("count4_after_reset", {28'b0, s_wb_count}, 32'd0);
      for (int i = 0; i < 32; i++) begin
         rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
         #1;
         check("reset_rs1", rs1_data, 32'h0);
         check("reset_rs2", rs2_data, 32'h0);
      end

      // ALU writeback to x5 with bypass, then array read
      regWrite_fin = 1'b1; memtoReg_fin = 1'b0; ALU_res_fin = 32'h1234_5678; rd_fin = 5'd5;
      rs1_addr = 5'd5; rs2_addr = 5'd6;
      #1;
      check("x5_bypass", rs1_data, 32'h1234_5678);
      check("x5_commit", {31'b0, wb_commit}, 32'h1);
      check("x6_untouched", rs2_data, 32'h0);
      tick();
      idle();
      #1;
      check("x5_array", rs1_data, 32'h1234_5678);
      check("count_1", wb_count, 32'd1);

      // Load writeback to x7
      regWrite_fin = 1'b1; memtoReg_fin = 1'b1; DM_read_data_out = 32'hDEAD_BEEF;
      ALU_res_fin = 32'h0000_0001; rd_fin = 5'd7; rs2_addr = 5'd7;
      #1;
      check("wb_data_load", wb_data, 32'hDEAD_BEEF);
      check("x7_bypass", rs2_data, 32'hDEAD_BEEF);
      tick();
      idle(); rs1_addr = 5'd7; rs2_addr = 5'd5;
      #1;
      check("x7_array", rs1_data, 32'hDEAD_BEEF);
      check("x5_still", rs2_data, 32'h1234_5678);
      check("count_2", wb_count, 32'd2);
      // wb_data follows inputs even without regWrite
      memtoReg_fin = 1'b0; ALU_res_fin = 32'hCAFE_0001;
      #1;
      check("wb_data_nowrite", wb_data, 32'hCAFE_0001);
      check("nowrite_commit", {31'b0, wb_commit}, 32'h0);
      idle();

      // Writes to x0 are ignored
      regWrite_fin = 1'b1; ALU_res_fin = 32'hFFFF_FFFF; rd_fin = 5'd0;
      rs1_addr = 5'd0; rs2_addr = 5'd0;
      #1;
      check("x0_rs1_same", rs1_data, 32'h0);
      check("x0_rs2_same", rs2_data, 32'h0);
      check("x0_commit", {31'b0, wb_commit}, 32'h0);
      tick();
      #1;
      check("x0_rs1_next", rs1_data, 32'h0);
      check("x0_rs2_next", rs2_data, 32'h0);
      check("x0_count", wb_count, 32'd2);
      idle();

      // Both ports bypass, then back-to-back writes to the same register
      regWrite_fin = 1'b1; ALU_res_fin = 32'h0000_0055; rd_fin = 5'd9;
      rs1_addr = 5'd9; rs2_addr = 5'd9;
      #1;
      check("dual_bypass_rs1", rs1_data, 32'h0000_0055);
      check("dual_bypass_rs2", rs2_data, 32'h0000_0055);
      tick();
      ALU_res_fin = 32'h0000_0066;
      #1;
      check("b2b_bypass", rs1_data, 32'h0000_0066);
      tick();
      idle();
      #1;
      check("b2b_array", rs2_data, 32'h0000_0066);
      check("count_4", wb_count, 32'd4);

      // Reset drops a simultaneous commit
      write_alu(5'd3, 32'h0000_000A);
      rs1_addr = 5'd3;
      #1;
      check("x3_written", rs1_data, 32'h0000_000A);
      rst = 1'b1; regWrite_fin = 1'b1; ALU_res_fin = 32'h0000_000B; rd_fin = 5'd3;
      #1;
      check("rst_wb_data", wb_data, 32'h0000_000B);
      check("rst_commit", {31'b0, wb_commit}, 32'h0);
      tick();
      rst = 1'b0; idle();
      #1;
      check("x3_after_rst", rs1_data, 32'h0);
      check("count_after_rst", wb_count, 32'd0);
      check("count4_after_rst", {28'b0, s_wb_count}, 32'd0);

      // 15 commits interleaved with x0 writes, then one more to wrap the 4-bit counter
      for (int i = 1; i <= 15; i++) begin
         write_alu(5'(i), 32'(i * 3));
         write_alu(5'd0, 32'hFFFF_0000);
      end
      #1;
      check("count4_15", {28'b0, s_wb_count}, 32'd15);
      check("count_15", wb_count, 32'd15);
      rs1_addr = 5'd15; rs2_addr = 5'd10;
      #1;
      check("x15_array", rs1_data, 32'd45);
      check("x10_array", rs2_data, 32'd30);
      write_alu(5'd20, 32'h0000_0BAD);
      #1;
      check("count4_wrap", {28'b0, s_wb_count}, 32'd0);
      check("count_16", wb_count, 32'd16);

      // Flushed bubble changes nothing
      idle();
      tick();
      #1;
      check("bubble_count", wb_count, 32'd16);
      check("bubble_x15", rs1_data, 32'd45);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
